vecmat_mac_engine: RTL and testbench
====================================

Name: vecmat_mac_engine

Overview:
- Sequential vector x matrix multiply-accumulate engine; the responder side of the enable/done handshake issued by a layer controller.
- Computes data_out[j] = sat32( bias[j] + sum_k data_in[k]*weights[k][j] ), PyTorch convention: row vector times weight matrix plus bias.
- One shared 32x32 signed multiplier, one MAC per cycle, iterating column-major over the weight matrix.
- Instantiated under the linear layer; fills the gap left by the missing bias add.

Parameters:
- INPUT_SIZE, 4, length of input vector / rows of weights (>=1)
- OUTPUT_SIZE, 4, length of output vector / columns of weights (>=1)
- SATURATE, 1, 1 = clamp final sum to signed 32-bit range; 0 = keep low 32 bits (wrap)

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- enable  input  1  level request from controller; high = compute/hold result, low = release
- data_in  input  32 x INPUT_SIZE  signed input vector
- weights  input  32 x INPUT_SIZE x OUTPUT_SIZE  signed weight matrix
- biases  input  32 x OUTPUT_SIZE  signed bias vector
- done  output  1  result valid; held while enable stays high
- busy  output  1  high in LOAD and RUN
- data_out  output  32 x OUTPUT_SIZE  signed result vector

Behaviour:
- Reset (rst=0, async): state=IDLE, done=0, busy=0, data_out all 0, counters k,j=0, accumulator=0. Takes effect immediately, including mid-computation; no partial result survives.
- States: IDLE, LOAD, RUN, DONE.
- IDLE: enable=1 at an edge -> LOAD. Otherwise stay. data_out holds the last result.
- LOAD (1 cycle): snapshot data_in, weights, biases into internal registers; acc=0, k=0, j=0; -> RUN. Input changes after this edge do not affect the result.
- RUN: each cycle acc_next = acc + sext64(x[k])*sext64(w[k][j]), 64-bit signed, wraps in 64 bits.
  - If k<INPUT_SIZE-1: k++.
  - If k=INPUT_SIZE-1: data_out[j] <= final(acc_next + sext64(b[j])); acc=0; k=0; j++.
  - If that was j=OUTPUT_SIZE-1: -> DONE.
- final(): SATURATE=1 clamps to [-2^31, 2^31-1]; SATURATE=0 takes bits [31:0].
- data_out[j] updates one element at a time during RUN. It is only guaranteed coherent while done=1.
- DONE: done=1, busy=0. Stay while enable=1. On enable=0 -> IDLE, and done=0 from the next edge.
- Latency: with enable first sampled high at edge 0, done is high after edge INPUT_SIZE*OUTPUT_SIZE+1. For 4x4, done is visible after edge 17, i.e. 17 cycles.
- Abort: enable=0 sampled in LOAD or RUN -> IDLE, done stays 0, busy=0. Partially written data_out elements remain. The next enable restarts from LOAD.
- Re-trigger: enable low for at least 1 cycle then high starts a new computation. enable held high after DONE does not restart.
- INPUT_SIZE=1 or OUTPUT_SIZE=1 are legal; the counters must not overflow or skip.

Test Plan:
- Identity: INPUT_SIZE=OUTPUT_SIZE=4, weights=I, biases=0, data_in={1,2,3,4}, enable held high -> done rises after 17 cycles, data_out={1,2,3,4}, busy high for cycles 1..16.
- Bias and signs: data_in={-2,3,0,5}, all weights=7, biases={10,-10,0,100} -> data_out={52,32,42,142}. Drop enable -> done=0 after one edge, data_out unchanged.
- Saturation: data_in all 0x40000000, weights all 4, bias 0 -> sum=2^34 -> data_out all 0x7FFFFFFF. Same with SATURATE=0 -> all 0x00000000. Negative mirror case -> 0x80000000.
- Snapshot: change data_in to garbage on the cycle after LOAD -> result equals the original-input result.
- Abort and reset: drop enable at RUN cycle 5 -> IDLE, done never asserts; re-enable -> correct result after 17 cycles. Assert rst mid-RUN -> done=0, busy=0, data_out=0 immediately, without waiting for a clock edge.
- Degenerate sizes: INPUT_SIZE=1, OUTPUT_SIZE=3, data_in={-4}, weights={1,2,3}, biases={0,1,2} -> data_out={-4,-7,-10}, done after 4 cycles.

Source files
------------

// File: rtl/vecmat_mac_engine_if.sv
// Request/result bundle between a layer controller (master) and the vector x matrix MAC engine (slave).
// Level enable in, done/busy/data_out back; sizes follow the engine instance.
interface vecmat_mac_engine_if #(
   parameter int INPUT_SIZE  = 4,
   parameter int OUTPUT_SIZE = 4
);
   logic                                      enable;
   logic [INPUT_SIZE-1:0][31:0]               data_in;
   logic [INPUT_SIZE-1:0][OUTPUT_SIZE-1:0][31:0] weights;
   logic [OUTPUT_SIZE-1:0][31:0]              biases;
   logic                                      done;
   logic                                      busy;
   logic [OUTPUT_SIZE-1:0][31:0]              data_out;

   modport master (
      output enable, data_in, weights, biases,
      input  done, busy, data_out
   );

   modport slave (
      input  enable, data_in, weights, biases,
      output done, busy, data_out
   );
endinterface

// File: rtl/vecmat_mac_engine.sv
// Row vector x weight matrix + bias, one shared 32x32 MAC per cycle; done after INPUT_SIZE*OUTPUT_SIZE+1 edges.
// No backpressure: result is held while enable stays high, enable low aborts or releases.
module vecmat_mac_engine #(
   parameter int INPUT_SIZE  = 4,
   parameter int OUTPUT_SIZE = 4,
   parameter int SATURATE    = 1
) (
   input logic                clk,
   input logic                rst,
   vecmat_mac_engine_if.slave mac_if
);

   localparam int KW = (INPUT_SIZE  > 1) ? $clog2(INPUT_SIZE)  : 1;
   localparam int JW = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(INPUT_SIZE - 1);
   localparam logic [JW-1:0] J_LAST = JW'(OUTPUT_SIZE - 1);
   localparam logic signed [63:0] SAT_MAX = 64'sh0000_0000_7FFF_FFFF;
   localparam logic signed [63:0] SAT_MIN = 64'shFFFF_FFFF_8000_0000;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [KW-1:0]                                r_k;
   logic [JW-1:0]                                r_j;
   logic signed [63:0]                           r_acc;
   logic [INPUT_SIZE-1:0][31:0]                  r_x;
   logic [INPUT_SIZE-1:0][OUTPUT_SIZE-1:0][31:0] r_w;
   logic [OUTPUT_SIZE-1:0][31:0]                 r_b;
   logic [OUTPUT_SIZE-1:0][31:0]                 r_dout;

   logic                w_k_last;
   logic                w_j_last;
   logic [31:0]         w_x_op;
   logic [31:0]         w_w_op;
   logic [31:0]         w_b_op;
   logic signed [63:0]  w_x_ext;
   logic signed [63:0]  w_w_ext;
   logic signed [63:0]  w_b_ext;
   logic signed [63:0]  w_prod;
   logic signed [63:0]  w_acc_nxt;
   logic signed [63:0]  w_total;
   logic [31:0]         w_final;

   assign w_k_last = (r_k == K_LAST);
   assign w_j_last = (r_j == J_LAST);

   // Operands come from the snapshot registers only, so live inputs cannot disturb a run.
   assign w_x_op  = r_x[r_k];
   assign w_w_op  = r_w[r_k][r_j];
   assign w_b_op  = r_b[r_j];
   assign w_x_ext = $signed({{32{w_x_op[31]}}, w_x_op});
   assign w_w_ext = $signed({{32{w_w_op[31]}}, w_w_op});
   assign w_b_ext = $signed({{32{w_b_op[31]}}, w_b_op});

   assign w_prod    = w_x_ext * w_w_ext;
   assign w_acc_nxt = r_acc + w_prod;
   assign w_total   = w_acc_nxt + w_b_ext;

   always_comb begin
      w_final = w_total[31:0];
      if (SATURATE != 0) begin
         if (w_total > SAT_MAX) begin
            w_final = 32'h7FFF_FFFF;
         end else if (w_total < SAT_MIN) begin
            w_final = 32'h8000_0000;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // enable low in any non-idle state returns to IDLE; this covers both abort and release.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (mac_if.enable) w_state_nxt = S_LOAD;
         end
         S_LOAD: begin
            w_state_nxt = mac_if.enable ? S_RUN : S_IDLE;
         end
         S_RUN: begin
            if (!mac_if.enable) begin
               w_state_nxt = S_IDLE;
            end else if (w_k_last && w_j_last) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (!mac_if.enable) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      mac_if.done = 1'b0;
      mac_if.busy = 1'b0;
      case (r_state)
         S_LOAD, S_RUN: mac_if.busy = 1'b1;
         S_DONE:        mac_if.done = 1'b1;
         default:       ;
      endcase
   end

   assign mac_if.data_out = r_dout;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_k    <= '0;
         r_j    <= '0;
         r_acc  <= '0;
         r_x    <= '0;
         r_w    <= '0;
         r_b    <= '0;
         r_dout <= '0;
      end else if (mac_if.enable) begin
         case (r_state)
            S_LOAD: begin
               r_x   <= mac_if.data_in;
               r_w   <= mac_if.weights;
               r_b   <= mac_if.biases;
               r_acc <= '0;
               r_k   <= '0;
               r_j   <= '0;
            end
            S_RUN: begin
               if (w_k_last) begin
                  r_dout[r_j] <= w_final;
                  r_acc       <= '0;
                  r_k         <= '0;
                  r_j         <= w_j_last ? '0 : r_j + JW'(1);
               end else begin
                  r_acc <= w_acc_nxt;
                  r_k   <= r_k + KW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_vecmat_mac_engine.sv
// Directed scoreboard bench: stimulus pushes hand-computed results, per-DUT monitors compare on done rise.
module tb_vecmat_mac_engine;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   vecmat_mac_engine_if #(.INPUT_SIZE(4), .OUTPUT_SIZE(4)) ifa ();
   vecmat_mac_engine_if #(.INPUT_SIZE(4), .OUTPUT_SIZE(4)) ifb ();
   vecmat_mac_engine_if #(.INPUT_SIZE(1), .OUTPUT_SIZE(3)) ifc ();

   vecmat_mac_engine #(.INPUT_SIZE(4), .OUTPUT_SIZE(4), .SATURATE(1)) u_sat  (.clk(clk), .rst(rst), .mac_if(ifa));
   vecmat_mac_engine #(.INPUT_SIZE(4), .OUTPUT_SIZE(4), .SATURATE(0)) u_wrap (.clk(clk), .rst(rst), .mac_if(ifb));
   vecmat_mac_engine #(.INPUT_SIZE(1), .OUTPUT_SIZE(3), .SATURATE(1)) u_deg  (.clk(clk), .rst(rst), .mac_if(ifc));

   typedef struct {
      string       name;
      logic [31:0] v [4];
      int          n;
      int          lat;
      int          start;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t qc[$];

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endfunction

   function automatic exp_t mk(input string nm, input int n, input int lat,
                               input logic [31:0] v0, input logic [31:0] v1,
                               input logic [31:0] v2, input logic [31:0] v3);
      exp_t e;
      e.name  = nm;
      e.n     = n;
      e.lat   = lat;
      e.start = cyc;
      e.v     = '{v0, v1, v2, v3};
      return e;
   endfunction

   function automatic void check_done(input exp_t e, input logic [127:0] dout, input logic busy);
      for (int i = 0; i < e.n; i++) begin
         chk($sformatf("%s_out%0d", e.name, i), dout[i*32 +: 32], e.v[i]);
      end
      chk({e.name, "_latency"}, 32'(cyc - e.start - 1), 32'(e.lat));
      chk({e.name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
   endfunction

   function automatic void spurious(input string nm);
      n_vec++;
      n_bad++;
      $display("FAIL %s: got done=1 want no done (nothing expected)", nm);
   endfunction

   logic pa = 1'b0, pb = 1'b0, pc = 1'b0;

   always @(negedge clk) begin
      if (ifa.done && !pa) begin
         if (qa.size() == 0) spurious("spurious_done_sat");
         else check_done(qa.pop_front(), ifa.data_out, ifa.busy);
      end
      if (ifb.done && !pb) begin
         if (qb.size() == 0) spurious("spurious_done_wrap");
         else check_done(qb.pop_front(), ifb.data_out, ifb.busy);
      end
      if (ifc.done && !pc) begin
         if (qc.size() == 0) spurious("spurious_done_deg");
         else check_done(qc.pop_front(), {32'd0, ifc.data_out}, ifc.busy);
      end
      pa = ifa.done;
      pb = ifb.done;
      pc = ifc.done;
   end

   task automatic wait_done(input int which, input string nm);
      int   t = 0;
      logic d = 1'b0;
      do begin
         @(negedge clk);
         t++;
         d = (which == 0) ? ifa.done : (which == 1) ? ifb.done : ifc.done;
      end while (!d && t < 40);
      if (!d) begin
         n_vec++;
         n_bad++;
         $display("FAIL %s_timeout: got done=0 want done=1 within 40 cycles", nm);
      end
   endtask

   task automatic set_ab(input int which, input logic [31:0] x0, input logic [31:0] x1,
                         input logic [31:0] x2, input logic [31:0] x3, input logic [31:0] wv,
                         input bit ident, input logic [31:0] b0, input logic [31:0] b1,
                         input logic [31:0] b2, input logic [31:0] b3);
      logic [3:0][31:0]       x;
      logic [3:0][31:0]       b;
      logic [3:0][3:0][31:0]  w;
      x = {x3, x2, x1, x0};
      b = {b3, b2, b1, b0};
      for (int k = 0; k < 4; k++) begin
         for (int j = 0; j < 4; j++) begin
            w[k][j] = ident ? ((k == j) ? 32'd1 : 32'd0) : wv;
         end
      end
      if (which == 0) begin
         ifa.data_in = x; ifa.weights = w; ifa.biases = b;
      end else begin
         ifb.data_in = x; ifb.weights = w; ifb.biases = b;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      ifa.enable = 1'b0; ifb.enable = 1'b0; ifc.enable = 1'b0;
      set_ab(0, 0, 0, 0, 0, 0, 1'b0, 0, 0, 0, 0);
      set_ab(1, 0, 0, 0, 0, 0, 1'b0, 0, 0, 0, 0);
      ifc.data_in = '0; ifc.weights = '0; ifc.biases = '0;

      repeat (3) @(negedge clk);
      chk("reset_done", {31'd0, ifa.done}, 32'd0);
      chk("reset_busy", {31'd0, ifa.busy}, 32'd0);
      for (int i = 0; i < 4; i++) chk($sformatf("reset_out%0d", i), ifa.data_out[i], 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // Identity matrix, zero bias, enable held through DONE.
      set_ab(0, 1, 2, 3, 4, 0, 1'b1, 0, 0, 0, 0);
      qa.push_back(mk("identity", 4, 17, 1, 2, 3, 4));
      ifa.enable = 1'b1;
      @(negedge clk);
      chk("identity_busy_load", {31'd0, ifa.busy}, 32'd1);
      repeat (8) @(negedge clk);
      chk("identity_busy_run", {31'd0, ifa.busy}, 32'd1);
      chk("identity_done_run", {31'd0, ifa.done}, 32'd0);
      wait_done(0, "identity");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("hold_done", {31'd0, ifa.done}, 32'd1);
         chk("hold_busy", {31'd0, ifa.busy}, 32'd0);
      end
      ifa.enable = 1'b0;
      @(negedge clk);

      // Signed inputs, uniform weights, per-column bias; release and check held result.
      set_ab(0, -2, 3, 0, 5, 7, 1'b0, 10, -10, 0, 100);
      qa.push_back(mk("bias_signs", 4, 17, 52, 32, 42, 142));
      ifa.enable = 1'b1;
      wait_done(0, "bias_signs");
      ifa.enable = 1'b0;
      @(negedge clk);
      chk("release_done", {31'd0, ifa.done}, 32'd0);
      chk("release_out0", ifa.data_out[0], 32'd52);
      chk("release_out1", ifa.data_out[1], 32'd32);
      chk("release_out2", ifa.data_out[2], 32'd42);
      chk("release_out3", ifa.data_out[3], 32'd142);

      // Inputs scrambled after the LOAD edge must not affect the result.
      qa.push_back(mk("snapshot", 4, 17, 52, 32, 42, 142));
      ifa.enable = 1'b1;
      repeat (2) @(negedge clk);
      set_ab(0, 32'h1234_5678, 32'h9ABC_DEF0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 32'h5555_AAAA,
             1'b0, 32'h7777_7777, 32'h8888_8888, 32'h1, 32'h2);
      wait_done(0, "snapshot");
      ifa.enable = 1'b0;
      @(negedge clk);

      // 4 * 2^30 * 4 = 2^34: clamps when saturating, wraps to zero otherwise.
      set_ab(0, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 4, 1'b0, 0, 0, 0, 0);
      set_ab(1, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 4, 1'b0, 0, 0, 0, 0);
      qa.push_back(mk("sat_pos", 4, 17, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF));
      qb.push_back(mk("wrap_pos", 4, 17, 0, 0, 0, 0));
      ifa.enable = 1'b1; ifb.enable = 1'b1;
      wait_done(0, "sat_pos");
      wait_done(1, "wrap_pos");
      ifa.enable = 1'b0; ifb.enable = 1'b0;
      @(negedge clk);

      set_ab(0, 32'hC000_0000, 32'hC000_0000, 32'hC000_0000, 32'hC000_0000, 4, 1'b0, 0, 0, 0, 0);
      set_ab(1, 32'hC000_0000, 32'hC000_0000, 32'hC000_0000, 32'hC000_0000, 4, 1'b0, 0, 0, 0, 0);
      qa.push_back(mk("sat_neg", 4, 17, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000));
      qb.push_back(mk("wrap_neg", 4, 17, 0, 0, 0, 0));
      ifa.enable = 1'b1; ifb.enable = 1'b1;
      wait_done(0, "sat_neg");
      wait_done(1, "wrap_neg");
      ifa.enable = 1'b0; ifb.enable = 1'b0;
      @(negedge clk);

      // Abort mid-RUN: no done may appear (monitor flags any), then a clean restart.
      set_ab(0, 1, 2, 3, 4, 0, 1'b1, 0, 0, 0, 0);
      ifa.enable = 1'b1;
      repeat (6) @(negedge clk);
      ifa.enable = 1'b0;
      @(negedge clk);
      chk("abort_done", {31'd0, ifa.done}, 32'd0);
      chk("abort_busy", {31'd0, ifa.busy}, 32'd0);
      repeat (20) @(negedge clk);
      qa.push_back(mk("after_abort", 4, 17, 1, 2, 3, 4));
      ifa.enable = 1'b1;
      wait_done(0, "after_abort");
      ifa.enable = 1'b0;
      @(negedge clk);

      // Asynchronous reset between clock edges clears everything at once.
      set_ab(0, -2, 3, 0, 5, 7, 1'b0, 10, -10, 0, 100);
      ifa.enable = 1'b1;
      repeat (8) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("async_rst_done", {31'd0, ifa.done}, 32'd0);
      chk("async_rst_busy", {31'd0, ifa.busy}, 32'd0);
      for (int i = 0; i < 4; i++) chk($sformatf("async_rst_out%0d", i), ifa.data_out[i], 32'd0);
      ifa.enable = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Degenerate 1x3 engine.
      ifc.data_in[0]    = -4;
      ifc.weights[0][0] = 1;
      ifc.weights[0][1] = 2;
      ifc.weights[0][2] = 3;
      ifc.biases[0]     = 0;
      ifc.biases[1]     = 1;
      ifc.biases[2]     = 2;
      qc.push_back(mk("degenerate", 3, 4, -4, -7, -10, 0));
      ifc.enable = 1'b1;
      wait_done(2, "degenerate");
      ifc.enable = 1'b0;
      repeat (3) @(negedge clk);

      chk("pending_sat",  32'(qa.size()), 32'd0);
      chk("pending_wrap", 32'(qb.size()), 32'd0);
      chk("pending_deg",  32'(qc.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
